systolic_dot_ctrl: RTL and testbench

SYSTOLIC_DOT_CTRL -- requirements
Module: systolic_dot_ctrl

---
 rtl/systolic_dot_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_systolic_dot_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_dot_ctrl.sv
// rtl/systolic_dot_ctrl.sv - skew/tag controller for a chained-DSP dot-product array; optional saturation via SYSTOLIC_DOT_CTRL_SAT_EN
module systolic_dot_ctrl #(
   parameter int NUM            = 4,
   parameter int AX_WIDTH       = 27,
   parameter int AY_WIDTH       = 27,
   parameter int RESULT_A_WIDTH = 64,
   parameter int ARRAY_LAT      = 6,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM*AX_WIDTH-1:0]   in_x,
   input  logic [NUM*AY_WIDTH-1:0]   in_y,
   input  logic                      in_last,
   output logic [NUM*AX_WIDTH-1:0]   arr_ax,
   output logic [NUM*AY_WIDTH-1:0]   arr_ay,
   input  logic [RESULT_A_WIDTH-1:0] arr_result,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [RESULT_A_WIDTH-1:0] out_data,
   output logic                      out_sat,
   output logic                      busy
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int MSB   = RESULT_A_WIDTH - 1;

   typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_t;

   state_t                    state_q;
   logic [CNT_W-1:0]          pending_q;
   logic                      accept;
   logic                      pop;
   logic                      push;

   logic [ARRAY_LAT:0]        tag_v_q;
   logic [ARRAY_LAT:0]        tag_f_q;
   logic [ARRAY_LAT:0]        tag_l_q;
   logic                      tag_hit;
   logic                      tag_first;
   logic                      tag_last;

   logic [RESULT_A_WIDTH-1:0] acc_q;
   logic [RESULT_A_WIDTH-1:0] acc_d;
   logic [RESULT_A_WIDTH-1:0] acc_base;
   logic [RESULT_A_WIDTH-1:0] acc_sum;

   logic [RESULT_A_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_q;
   logic [PTR_W-1:0]          rd_q;
   logic [CNT_W-1:0]          cnt_q;

`ifdef SYSTOLIC_DOT_CTRL_SAT_EN
   localparam logic [RESULT_A_WIDTH-1:0] SMAX = {1'b0, {(RESULT_A_WIDTH-1){1'b1}}};
   localparam logic [RESULT_A_WIDTH-1:0] SMIN = {1'b1, {(RESULT_A_WIDTH-1){1'b0}}};
   logic sat_q;
   logic sat_d;
   logic ovf;
   logic sat_mem_q [FIFO_DEPTH];
`endif

   // An open group must always be allowed to finish; new groups need a reserved FIFO slot
   assign in_ready = (state_q == OPEN) || (pending_q < CNT_W'(FIFO_DEPTH));
   assign accept   = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

   // Group framing FSM and count of groups that own a FIFO slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         if (accept) begin
            state_q <= in_last ? IDLE : OPEN;
         end
         pending_q <= pending_q + CNT_W'(accept && (state_q == IDLE)) - CNT_W'(pop);
      end
   end

   // Lane k is delayed k extra cycles so each beat walks diagonally through the chained stages
   for (genvar k = 0; k < NUM; k++) begin : g_lane
      logic [AX_WIDTH-1:0] x_q [k+1];
      logic [AY_WIDTH-1:0] y_q [k+1];
      logic [k:0]          v_q;

      // Per-lane delay line; stage 0 loads zero on idle cycles
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= '0;
            for (int s = 0; s <= k; s++) begin
               x_q[s] <= '0;
               y_q[s] <= '0;
            end
         end else begin
            v_q[0] <= accept;
            x_q[0] <= accept ? in_x[k*AX_WIDTH +: AX_WIDTH] : '0;
            y_q[0] <= accept ? in_y[k*AY_WIDTH +: AY_WIDTH] : '0;
            for (int s = 1; s <= k; s++) begin
               v_q[s] <= v_q[s-1];
               x_q[s] <= x_q[s-1];
               y_q[s] <= y_q[s-1];
            end
         end
      end

      assign arr_ax[k*AX_WIDTH +: AX_WIDTH] = v_q[k] ? x_q[k] : '0;
      assign arr_ay[k*AY_WIDTH +: AY_WIDTH] = v_q[k] ? y_q[k] : '0;
   end

   // Beat tag follows lane 0 so it lines up with the array result of the same beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v_q <= '0;
         tag_f_q <= '0;
         tag_l_q <= '0;
      end else begin
         tag_v_q <= {tag_v_q[ARRAY_LAT-1:0], accept};
         tag_f_q <= {tag_f_q[ARRAY_LAT-1:0], accept && (state_q == IDLE)};
         tag_l_q <= {tag_l_q[ARRAY_LAT-1:0], accept && in_last};
      end
   end

   assign tag_hit   = tag_v_q[ARRAY_LAT];
   assign tag_first = tag_f_q[ARRAY_LAT];
   assign tag_last  = tag_l_q[ARRAY_LAT];
   assign push      = tag_hit && tag_last;

   // Next accumulator value: restart on the first beat of a group, clamp on signed overflow if enabled
   always_comb begin
      acc_base = tag_first ? '0 : acc_q;
      acc_sum  = acc_base + arr_result;
`ifdef SYSTOLIC_DOT_CTRL_SAT_EN
      ovf   = (acc_base[MSB] == arr_result[MSB]) && (acc_sum[MSB] != acc_base[MSB]);
      sat_d = (tag_first ? 1'b0 : sat_q) | ovf;
      if (ovf) begin
         acc_d = acc_base[MSB] ? SMIN : SMAX;
      end else begin
         acc_d = acc_sum;
      end
`else
      acc_d = acc_sum;
`endif
   end

   // Accumulator only moves on tagged cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
`ifdef SYSTOLIC_DOT_CTRL_SAT_EN
         sat_q <= 1'b0;
`endif
      end else if (tag_hit) begin
         acc_q <= acc_d;
`ifdef SYSTOLIC_DOT_CTRL_SAT_EN
         sat_q <= sat_d;
`endif
      end
   end

   // Result FIFO pointers and occupancy; push and pop may coincide, even when full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            wr_q <= wr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_q <= rd_q + PTR_W'(1);
         end
         cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // FIFO storage needs no reset: the head is masked to zero whenever the FIFO is empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q] <= acc_d;
`ifdef SYSTOLIC_DOT_CTRL_SAT_EN
         sat_mem_q[wr_q] <= sat_d;
`endif
      end
   end

   assign out_valid = (cnt_q != '0);
   assign out_data  = out_valid ? mem_q[rd_q] : '0;
`ifdef SYSTOLIC_DOT_CTRL_SAT_EN
   assign out_sat   = out_valid && sat_mem_q[rd_q];
`else
   assign out_sat   = 1'b0;
`endif
   assign busy      = (state_q == OPEN) || (|tag_v_q) || out_valid;

endmodule

// File: tb/tb_systolic_dot_ctrl.sv
// tb/tb_systolic_dot_ctrl.sv - table-driven self-checking bench for systolic_dot_ctrl with a behavioural DSP chain
module tb_systolic_dot_ctrl;
   localparam int NUM = 4;
   localparam int AXW = 27;
   localparam int AYW = 27;
   localparam int RW  = 64;
   localparam int LAT = 6;
   localparam int DEP = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [NUM*AXW-1:0] in_x;
   logic [NUM*AYW-1:0] in_y;
   logic              in_last;
   logic [NUM*AXW-1:0] arr_ax;
   logic [NUM*AYW-1:0] arr_ay;
   logic [RW-1:0]     arr_result;
   logic              out_valid;
   logic              out_ready;
   logic [RW-1:0]     out_data;
   logic              out_sat;
   logic              busy;

   always #5 clk = ~clk;

   systolic_dot_ctrl #(
      .NUM(NUM), .AX_WIDTH(AXW), .AY_WIDTH(AYW), .RESULT_A_WIDTH(RW),
      .ARRAY_LAT(LAT), .FIFO_DEPTH(DEP)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_last(in_last),
      .arr_ax(arr_ax), .arr_ay(arr_ay), .arr_result(arr_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .busy(busy)
   );

   // DSP chain model: lane k product reaches the result LAT-k cycles after it is driven
   longint pd [NUM][LAT];
   always @(posedge clk) begin
      for (int k = 0; k < NUM; k++) begin
         pd[k][0] <= longint'($signed(arr_ax[k*AXW +: AXW])) * longint'($signed(arr_ay[k*AYW +: AYW]));
         for (int j = 1; j < LAT; j++) pd[k][j] <= pd[k][j-1];
      end
   end
   always_comb begin
      arr_result = '0;
      for (int k = 0; k < NUM; k++) arr_result = arr_result + pd[k][LAT-1-k];
   end

   typedef struct {
      logic [NUM*AXW-1:0] x;
      logic [NUM*AYW-1:0] y;
      logic [RW-1:0]      exp;
   } vec_t;
   vec_t tbl [6];

   int n_chk  = 0;
   int n_pass = 0;

   function automatic logic [NUM*AXW-1:0] pack4(input int a, input int b, input int c, input int d);
      return {d[26:0], c[26:0], b[26:0], a[26:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic expect_out(input string name, input logic [63:0] exp_data, input logic exp_sat);
      int g = 0;
      while (!out_valid && g < 40) begin
         @(negedge clk);
         g++;
      end
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_data"}, out_data, exp_data);
      chk({name, "_sat"}, out_sat, exp_sat);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, sent, stalls, seen;
      logic rdy;
      logic [63:0] big_exp;
      logic big_sat;

      tbl[0] = '{pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 64'd70};
      tbl[1] = '{pack4(-1, -2, -3, -4), pack4(5, 6, 7, 8), -64'sd70};
      tbl[2] = '{pack4(-67108864, -67108864, -67108864, -67108864),
                 pack4(-67108864, -67108864, -67108864, -67108864), 64'd18014398509481984};
      tbl[3] = '{pack4(67108863, 0, 0, 0), pack4(-67108864, 0, 0, 0), -64'sd4503599560261632};
      tbl[4] = '{pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 64'd0};
      tbl[5] = '{pack4(100, -200, 300, -400), pack4(-7, 9, -11, 13), -64'sd11000};

      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_busy", busy, 0);
      chk("rst_arr_ax", arr_ax[63:0], 0);
      chk("rst_arr_ay", arr_ay[63:0], 0);
      rst_n = 1'b1;

      // Single-beat groups: latency, skew and sum
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_x = tbl[i].x; in_y = tbl[i].y; in_last = 1'b1;
         chk("tbl_in_ready", in_ready, 1);
         @(posedge clk);
         n = 0;
         do begin
            @(negedge clk);
            if (n == 0) in_valid = 1'b0;
            n++;
            if (n == 1) chk("tbl_lane0_drive", arr_ax[26:0], tbl[i].x[26:0]);
            if (n == 2) chk("tbl_lane0_idle", arr_ax[26:0], 0);
            if (n == 4) chk("tbl_lane3_drive", arr_ay[107:81], tbl[i].y[107:81]);
         end while (!out_valid && n < 20);
         chk("tbl_latency", n, 8);
         chk("tbl_data", out_data, tbl[i].exp);
         chk("tbl_sat", out_sat, 0);
      end
      @(negedge clk);
      chk("tbl_drained_valid", out_valid, 0);
      chk("tbl_drained_busy", busy, 0);

      // Three-beat group, back to back
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         in_valid = 1'b1; in_x = pack4(-3, -3, -3, -3); in_y = pack4(7, 7, 7, 7); in_last = (b == 2);
         chk("grp_in_ready", in_ready, 1);
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      expect_out("grp", -64'sd252, 1'b0);
      chk("grp_one_entry", out_valid, 0);

      // Backpressure: five single-beat groups against a stalled output
      out_ready = 1'b0;
      sent = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         in_valid = (sent < 5);
         in_x = pack4(sent + 1, sent + 1, sent + 1, sent + 1);
         in_y = pack4(1, 1, 1, 1);
         in_last = 1'b1;
         rdy = in_ready;
         @(posedge clk);
         if (in_valid && rdy) sent++;
      end
      @(negedge clk);
      chk("bp_accepted", sent, 4);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_head_data", out_data, 4);
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 4);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_reopen_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      expect_out("bp_q1", 64'd8, 1'b0);
      expect_out("bp_q2", 64'd12, 1'b0);
      expect_out("bp_q3", 64'd16, 1'b0);
      expect_out("bp_q4", 64'd20, 1'b0);
      chk("bp_busy_clear", busy, 0);

      // Open group must finish even when every FIFO slot is reserved
      out_ready = 1'b0;
      for (int s = 1; s <= 3; s++) begin
         @(negedge clk);
         in_valid = 1'b1; in_x = pack4(1, 1, 1, 1); in_y = pack4(s, s, s, s); in_last = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      in_x = pack4(1, 1, 1, 1); in_y = pack4(5, 5, 5, 5); in_last = 1'b0;
      chk("open_first_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (12) @(negedge clk);
      chk("open_out_valid", out_valid, 1);
      chk("open_in_ready", in_ready, 1);
      in_valid = 1'b1; in_y = pack4(6, 6, 6, 6); in_last = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      chk("closed_in_ready", in_ready, 0);
      repeat (10) @(negedge clk);
      out_ready = 1'b1;
      expect_out("full_q1", 64'd4, 1'b0);
      expect_out("full_q2", 64'd8, 1'b0);
      expect_out("full_q3", 64'd12, 1'b0);
      expect_out("full_q4", 64'd44, 1'b0);

      // Reset in the middle of a group flight
      @(negedge clk);
      in_valid = 1'b1; in_x = pack4(1, 2, 3, 4); in_y = pack4(5, 6, 7, 8); in_last = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid || busy) seen = 1;
      end
      chk("mid_rst_no_stale", seen, 0);

      // Long group crossing the signed accumulator limit
`ifdef SYSTOLIC_DOT_CTRL_SAT_EN
      big_exp = 64'h7FFF_FFFF_FFFF_FFFF;
      big_sat = 1'b1;
`else
      big_exp = 64'h8040_0000_0000_0000;
      big_sat = 1'b0;
`endif
      out_ready = 1'b0;
      stalls = 0;
      for (int b = 0; b < 513; b++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_x = pack4(-67108864, -67108864, -67108864, -67108864);
         in_y = pack4(-67108864, -67108864, -67108864, -67108864);
         in_last = (b == 512);
         if (!in_ready) stalls++;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      chk("big_no_stall", stalls, 0);
      out_ready = 1'b1;
      expect_out("big", big_exp, big_sat);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
